// File: rtl/fifo_unpacker_pkg.sv
// Shared FIFO helpers: chunk-order encodings and derived-width functions
// for blocks that split FIFO words into narrower chunks.
package fifo_unpacker_pkg;

  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

  // Width of one chunk when a word is split into ratio pieces.
  function automatic int unsigned chunk_width(input int unsigned wid, input int unsigned ratio);
    return (ratio == 0) ? wid : wid / ratio;
  endfunction

  // Index width able to count ratio chunks; never narrower than one bit.
  function automatic int unsigned index_width(input int unsigned ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// Pops WID-bit words from a FIFO read port and streams them out as RATIO
// narrower chunks over valid/ready, flagging the final chunk of each word.
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int unsigned WID       = 32,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned OWID      = chunk_width(WID, RATIO),
  parameter int unsigned IDXW      = index_width(RATIO),
  parameter bit          MSB_FIRST = ORDER_LSB_FIRST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            softreset,
  input  logic            fifo_empty,
  input  logic [WID-1:0]  fifo_data,
  output logic            fifo_readout,
  output logic            vldout,
  output logic [OWID-1:0] dataout,
  output logic            lastout,
  input  logic            readyin,
  output logic            busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(RATIO - 1);

  generate
    if ((WID % RATIO) != 0 || RATIO < 2) begin : g_bad_params
      $error("fifo_unpacker: WID must be divisible by RATIO and RATIO must be >= 2");
    end
  endgenerate

  logic [WID-1:0]  word_q, word_n;
  logic [IDXW-1:0] idx_q, idx_n;
  logic            have_q, have_n;
  logic [OWID-1:0] dout_q, dout_n;
  logic            last_q, last_n;
  logic            clr_c, take_c, pop_c;

  // Chunk i of a word in the configured emission order.
  function automatic logic [OWID-1:0] chunk_sel(input logic [WID-1:0] w,
                                                input logic [IDXW-1:0] i);
    int unsigned pos;
    pos = (MSB_FIRST == ORDER_MSB_FIRST) ? (RATIO - 1 - 32'(i)) : 32'(i);
    return w[pos*OWID +: OWID];
  endfunction

  assign clr_c  = rst || softreset;
  assign take_c = have_q && readyin;
  // Pop when idle, or when the final chunk leaves so the next word follows with no gap.
  assign pop_c  = !clr_c && !fifo_empty && (!have_q || (take_c && last_q));

  always_comb begin
    word_n = word_q;
    idx_n  = idx_q;
    have_n = have_q;
    if (pop_c) begin
      word_n = fifo_data;
      idx_n  = '0;
      have_n = 1'b1;
    end else if (take_c) begin
      if (last_q) begin
        idx_n  = '0;
        have_n = 1'b0;
      end else begin
        idx_n = idx_q + IDXW'(1);
      end
    end
    dout_n = have_n ? chunk_sel(word_n, idx_n) : '0;
    last_n = have_n && (idx_n == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (clr_c) begin
      word_q <= '0;
      idx_q  <= '0;
      have_q <= 1'b0;
      dout_q <= '0;
      last_q <= 1'b0;
    end else begin
      word_q <= word_n;
      idx_q  <= idx_n;
      have_q <= have_n;
      dout_q <= dout_n;
      last_q <= last_n;
    end
  end

  assign fifo_readout = pop_c;
  assign vldout       = have_q;
  assign busy         = have_q;
  assign dataout      = dout_q;
  assign lastout      = last_q;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Randomized bench for fifo_unpacker: LSB-first and MSB-first instances share
// one FIFO model and are checked against a chunk-level scoreboard.
module tb_fifo_unpacker;

  localparam int unsigned WID   = 32;
  localparam int unsigned RATIO = 4;
  localparam int unsigned OWID  = WID / RATIO;

  typedef struct {
    logic [OWID-1:0] lsb;
    logic [OWID-1:0] msb;
    bit              last;
  } chunk_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            softreset = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [WID-1:0]  fifo_data = '0;
  logic            readyin = 1'b0;
  bit              hold = 1'b0;

  logic            rd_l, vld_l, last_l, busy_l;
  logic [OWID-1:0] dout_l;
  logic            rd_m, vld_m, last_m, busy_m;
  logic [OWID-1:0] dout_m;

  logic [WID-1:0]  fq[$];
  chunk_t          exq[$];
  int              n_checks = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  fifo_unpacker #(.WID(WID), .RATIO(RATIO), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .softreset(softreset), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_readout(rd_l), .vldout(vld_l), .dataout(dout_l),
    .lastout(last_l), .readyin(readyin), .busy(busy_l)
  );

  fifo_unpacker #(.WID(WID), .RATIO(RATIO), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .softreset(softreset), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_readout(rd_m), .vldout(vld_m), .dataout(dout_m),
    .lastout(last_m), .readyin(readyin), .busy(busy_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Scoreboard: the expected chunk stream of the word currently held.
  always @(negedge clk) begin
    bit     clr, exp_vld, take, exp_pop;
    chunk_t c;
    logic [WID-1:0] w;
    clr     = rst || softreset;
    exp_vld = (exq.size() != 0);
    if (exp_vld) c = exq[0];
    else begin
      c.lsb  = '0;
      c.msb  = '0;
      c.last = 1'b0;
    end
    check("vld_lsb",  32'(vld_l),  32'(exp_vld));
    check("vld_msb",  32'(vld_m),  32'(exp_vld));
    check("busy_lsb", 32'(busy_l), 32'(exp_vld));
    check("busy_msb", 32'(busy_m), 32'(exp_vld));
    check("data_lsb", 32'(dout_l), 32'(c.lsb));
    check("data_msb", 32'(dout_m), 32'(c.msb));
    check("last_lsb", 32'(last_l), 32'(c.last));
    check("last_msb", 32'(last_m), 32'(c.last));
    take    = exp_vld && (readyin === 1'b1);
    exp_pop = !clr && !fifo_empty && (!exp_vld || (take && c.last));
    check("readout_lsb", 32'(rd_l), 32'(exp_pop));
    check("readout_msb", 32'(rd_m), 32'(exp_pop));
    if (clr) begin
      exq.delete();
    end else begin
      if (take) void'(exq.pop_front());
      if (exp_pop) begin
        w = fq.pop_front();
        for (int k = 0; k < int'(RATIO); k++) begin
          c.lsb  = OWID'(w >> (OWID * k));
          c.msb  = OWID'(w >> (OWID * (int'(RATIO) - 1 - k)));
          c.last = (k == int'(RATIO) - 1);
          exq.push_back(c);
        end
      end
    end
  end

  task automatic step(input bit r, input bit sr, input bit rdy, input bit hd);
    @(posedge clk);
    #1;
    rst        = r;
    softreset  = sr;
    readyin    = rdy;
    hold       = hd;
    fifo_empty = hd || (fq.size() == 0);
    fifo_data  = fifo_empty ? $urandom : fq[0];
  endtask

  initial begin
    // Reset with a word waiting: no pop may happen while rst is high.
    fq.push_back(32'hDDCCBBAA);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0);
    // Back-to-back words.
    fq.push_back(32'h44332211);
    fq.push_back(32'h88776655);
    repeat (11) step(1'b0, 1'b0, 1'b1, 1'b0);
    // Empty FIFO.
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0);
    // Backpressure on the second chunk.
    fq.push_back(32'hDDCCBBAA);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);
    // Softreset mid-word, then the next word starts at chunk 0.
    fq.push_back(32'hDDCCBBAA);
    fq.push_back(32'h44332211);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0);
    // Random traffic with gaps, backpressure and occasional resets.
    repeat (3000) begin
      if (($urandom % 3 == 0) && (fq.size() < 8)) fq.push_back($urandom);
      step(($urandom % 300) == 0, ($urandom % 97) == 0,
           ($urandom % 4) != 0, ($urandom % 8) == 0);
    end
    for (int i = 0; i < 200 && (fq.size() != 0 || exq.size() != 0); i++)
      step(1'b0, 1'b0, 1'b1, 1'b0);
    check("drained", 32'(fq.size() + exq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
